// File: rtl/wb_regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_sb_pkg
// Description : Shared constants and writeback-port enum for wb_regfile_sb.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_regfile_sb_pkg;

    localparam int XLEN      = 64;
    localparam int NREG      = 32;
    localparam int REGADDR_W = $clog2(NREG);
    localparam int CNT_W     = 2;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
    localparam int NRD       = 4;

    typedef enum logic [1:0] {
        WB_AO = 2'd0,
        WB_AT = 2'd1,
        WB_MM = 2'd2
    } wb_port_e;

endpackage
`default_nettype wire

// File: rtl/wb_pend_cnt.sv
`default_nettype none
// ============================================================================
// Module      : wb_pend_cnt
// Description : Per-register pending-write counter with overflow look-ahead
//               and saturating underflow detection.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_pend_cnt
    import wb_regfile_sb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       inc,
    input  logic [1:0]       dec,
    input  logic             accept,
    output logic [CNT_W-1:0] cnt,
    output logic             would_overflow,
    output logic             underflow
);

    localparam int SW = CNT_W + 2;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next;
    logic [SW-1:0]    w_cur;
    logic [SW-1:0]    w_req;
    logic [SW-1:0]    w_sum;
    logic [SW-1:0]    w_lim;

    assign w_cur = SW'(r_cnt);
    assign w_req = w_cur + SW'(inc);
    assign w_sum = accept ? w_req : w_cur;
    assign w_lim = SW'(dec) + SW'(CNT_MAX);

    // Overflow is judged on the requested increment so it can gate accept.
    assign would_overflow = (w_req > w_lim);
    assign underflow      = (SW'(dec) > w_sum);
    assign w_next         = underflow ? '0 : CNT_W'(w_sum - SW'(dec));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next;
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/wb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_sb
// Description : Writeback register file with per-register pending-write
//               scoreboard; 3 write ports, 4 read ports, dual dispatch.
//               Define WB_REGFILE_BYPASS_EN for same-cycle write bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile_sb
    import wb_regfile_sb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      ao_data,
    input  logic [REGADDR_W-1:0] ao_addr,
    input  logic                 ao_ena,
    input  logic [XLEN-1:0]      at_data,
    input  logic [REGADDR_W-1:0] at_addr,
    input  logic                 at_ena,
    input  logic [XLEN-1:0]      mm_data,
    input  logic [REGADDR_W-1:0] mm_addr,
    input  logic                 mm_ena,
    input  logic                 ds0_ena,
    input  logic [REGADDR_W-1:0] ds0_rd,
    input  logic                 ds1_ena,
    input  logic [REGADDR_W-1:0] ds1_rd,
    output logic                 ds_ready,
    input  logic [REGADDR_W-1:0] rs_addr [NRD],
    output logic [XLEN-1:0]      rs_data [NRD],
    output logic [NRD-1:0]       rs_busy,
    output logic                 sb_err
);

    logic [NRD-1:0]   w_we;
    logic             w_ds0_v;
    logic             w_ds1_v;
    logic [XLEN-1:0]  r_regs [NREG];
    logic [1:0]       w_inc  [NREG];
    logic [1:0]       w_dec  [NREG];
    logic [CNT_W-1:0] w_cnt  [NREG];
    logic [NREG-1:0]  w_ovf;
    logic [NREG-1:0]  w_unf;
    logic             r_sb_err;

    assign w_we[WB_AO] = ao_ena && (ao_addr != '0);
    assign w_we[WB_AT] = at_ena && (at_addr != '0);
    assign w_we[WB_MM] = mm_ena && (mm_addr != '0);
    assign w_we[3]     = 1'b0;
    assign w_ds0_v     = ds0_ena && (ds0_rd != '0);
    assign w_ds1_v     = ds1_ena && (ds1_rd != '0);

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            w_inc[r] = {1'b0, w_ds0_v && (ds0_rd == REGADDR_W'(r))}
                     + {1'b0, w_ds1_v && (ds1_rd == REGADDR_W'(r))};
            w_dec[r] = {1'b0, w_we[WB_AO] && (ao_addr == REGADDR_W'(r))}
                     + {1'b0, w_we[WB_AT] && (at_addr == REGADDR_W'(r))}
                     + {1'b0, w_we[WB_MM] && (mm_addr == REGADDR_W'(r))};
        end
    end

    assign w_cnt[0] = '0;
    assign w_ovf[0] = 1'b0;
    assign w_unf[0] = 1'b0;

    generate
        for (genvar g = 1; g < NREG; g++) begin : g_cnt
            wb_pend_cnt u_cnt (
                .clk            (clk),
                .rst            (rst),
                .inc            (w_inc[g]),
                .dec            (w_dec[g]),
                .accept         (ds_ready),
                .cnt            (w_cnt[g]),
                .would_overflow (w_ovf[g]),
                .underflow      (w_unf[g])
            );
        end
    endgenerate

    // All-or-nothing: any counter that would overflow rejects both slots.
    assign ds_ready = ~|w_ovf;

    // Later assignments win, giving mm > at > ao on address collisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_regs[r] <= '0;
            end
            r_sb_err <= 1'b0;
        end else begin
            if (w_we[WB_AO]) r_regs[ao_addr] <= ao_data;
            if (w_we[WB_AT]) r_regs[at_addr] <= at_data;
            if (w_we[WB_MM]) r_regs[mm_addr] <= mm_data;
            if (|w_unf) r_sb_err <= 1'b1;
        end
    end

    assign sb_err = r_sb_err;

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rs_data[i] = (rs_addr[i] == '0) ? '0 : r_regs[rs_addr[i]];
`ifdef WB_REGFILE_BYPASS_EN
            if (w_we[WB_AO] && (ao_addr == rs_addr[i])) rs_data[i] = ao_data;
            if (w_we[WB_AT] && (at_addr == rs_addr[i])) rs_data[i] = at_data;
            if (w_we[WB_MM] && (mm_addr == rs_addr[i])) rs_data[i] = mm_data;
            rs_busy[i] = (rs_addr[i] != '0)
                      && (int'(w_cnt[rs_addr[i]]) > int'(w_dec[rs_addr[i]]));
`else
            rs_busy[i] = (rs_addr[i] != '0) && (w_cnt[rs_addr[i]] != '0);
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile_sb
// Description : Scoreboard bench for wb_regfile_sb with directed scenarios
//               and randomized traffic against an array-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile_sb;
    import wb_regfile_sb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] ao_data, at_data, mm_data;
    logic [4:0]  ao_addr, at_addr, mm_addr;
    logic        ao_ena, at_ena, mm_ena;
    logic        ds0_ena, ds1_ena;
    logic [4:0]  ds0_rd, ds1_rd;
    logic        ds_ready;
    logic [4:0]  rs_addr [4];
    logic [63:0] rs_data [4];
    logic [3:0]  rs_busy;
    logic        sb_err;

    always #5 clk = ~clk;

    wb_regfile_sb dut (
        .clk(clk), .rst(rst),
        .ao_data(ao_data), .ao_addr(ao_addr), .ao_ena(ao_ena),
        .at_data(at_data), .at_addr(at_addr), .at_ena(at_ena),
        .mm_data(mm_data), .mm_addr(mm_addr), .mm_ena(mm_ena),
        .ds0_ena(ds0_ena), .ds0_rd(ds0_rd), .ds1_ena(ds1_ena), .ds1_rd(ds1_rd),
        .ds_ready(ds_ready), .rs_addr(rs_addr), .rs_data(rs_data),
        .rs_busy(rs_busy), .sb_err(sb_err)
    );

    typedef struct packed {
        logic            rst;
        logic            ao_e;  logic [4:0] ao_a; logic [63:0] ao_d;
        logic            at_e;  logic [4:0] at_a; logic [63:0] at_d;
        logic            mm_e;  logic [4:0] mm_a; logic [63:0] mm_d;
        logic            d0_e;  logic [4:0] d0_rd;
        logic            d1_e;  logic [4:0] d1_rd;
        logic [3:0][4:0] rs_a;
    } stim_t;

    typedef struct packed {
        logic             ready;
        logic             err;
        logic [3:0][63:0] data;
        logic [3:0]       busy;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] m_regs [32];
    int          m_cnt  [32];
    bit          m_err = 1'b0;

    function automatic stim_t idle(input logic [4:0] a0, a1, a2, a3);
        stim_t s;
        s      = '0;
        s.rs_a = {a3, a2, a1, a0};
        return s;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle, predict its outputs, then advance the model past the edge.
    task automatic step(input stim_t s, input bit chk);
        int   inc [32];
        int   dec [32];
        int   n;
        bit   rdy;
        exp_t e;
        logic [4:0] a;
        @(negedge clk);
        rst = s.rst;
        ao_ena = s.ao_e; ao_addr = s.ao_a; ao_data = s.ao_d;
        at_ena = s.at_e; at_addr = s.at_a; at_data = s.at_d;
        mm_ena = s.mm_e; mm_addr = s.mm_a; mm_data = s.mm_d;
        ds0_ena = s.d0_e; ds0_rd = s.d0_rd; ds1_ena = s.d1_e; ds1_rd = s.d1_rd;
        for (int i = 0; i < 4; i++) rs_addr[i] = s.rs_a[i];

        for (int r = 0; r < 32; r++) begin
            inc[r] = 0;
            dec[r] = 0;
        end
        if (s.d0_e && s.d0_rd != 0) inc[s.d0_rd]++;
        if (s.d1_e && s.d1_rd != 0) inc[s.d1_rd]++;
        if (s.ao_e && s.ao_a != 0) dec[s.ao_a]++;
        if (s.at_e && s.at_a != 0) dec[s.at_a]++;
        if (s.mm_e && s.mm_a != 0) dec[s.mm_a]++;
        rdy = 1'b1;
        for (int r = 1; r < 32; r++)
            if (inc[r] > 0 && m_cnt[r] + inc[r] - dec[r] > CNT_MAX) rdy = 1'b0;

        e.ready = rdy;
        e.err   = m_err;
        for (int i = 0; i < 4; i++) begin
            a = s.rs_a[i];
            e.data[i] = (a == 0) ? 64'd0 : m_regs[a];
            e.busy[i] = (a != 0) && (m_cnt[a] != 0);
`ifdef WB_REGFILE_BYPASS_EN
            if (a != 0) begin
                if (s.mm_e && s.mm_a == a)      e.data[i] = s.mm_d;
                else if (s.at_e && s.at_a == a) e.data[i] = s.at_d;
                else if (s.ao_e && s.ao_a == a) e.data[i] = s.ao_d;
                e.busy[i] = (m_cnt[a] - dec[a]) > 0;
            end
`endif
        end
        if (chk) sbq.push_back(e);

        if (s.rst) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = 64'd0;
                m_cnt[r]  = 0;
            end
            m_err = 1'b0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                n = m_cnt[r] + (rdy ? inc[r] : 0) - dec[r];
                if (n < 0) begin
                    n     = 0;
                    m_err = 1'b1;
                end
                m_cnt[r] = n;
            end
            if (s.mm_e && s.mm_a != 0)      m_regs[s.mm_a] = s.mm_d;
            if (s.at_e && s.at_a != 0 && !(s.mm_e && s.mm_a == s.at_a))
                m_regs[s.at_a] = s.at_d;
            if (s.ao_e && s.ao_a != 0 && !(s.mm_e && s.mm_a == s.ao_a)
                                      && !(s.at_e && s.at_a == s.ao_a))
                m_regs[s.ao_a] = s.ao_d;
        end
    endtask

    // Mostly retire writes to registers the model says are pending.
    function automatic logic [4:0] pick_wr();
        int start;
        int r;
        if ($urandom_range(0, 9) < 8) begin
            start = $urandom_range(1, 11);
            for (int k = 0; k < 11; k++) begin
                r = 1 + ((start - 1 + k) % 11);
                if (m_cnt[r] > 0) return 5'(r);
            end
        end
        return 5'($urandom_range(0, 11));
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                cmp("ds_ready", 64'(ds_ready), 64'(e.ready));
                cmp("sb_err", 64'(sb_err), 64'(e.err));
                for (int i = 0; i < 4; i++) begin
                    cmp($sformatf("rs_data[%0d]", i), rs_data[i], e.data[i]);
                    cmp($sformatf("rs_busy[%0d]", i), 64'(rs_busy[i]), 64'(e.busy[i]));
                end
            end
        end
    end

    initial begin : driver
        stim_t s;
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = 64'd0;
            m_cnt[r]  = 0;
        end
        s = idle(0, 0, 0, 0); s.rst = 1'b1;
        step(s, 1'b0);
        step(s, 1'b1);

        // Dispatch x5, retire it three cycles later.
        s = idle(5, 0, 5, 1); s.d0_e = 1'b1; s.d0_rd = 5'd5; step(s, 1'b1);
        step(idle(5, 0, 5, 1), 1'b1);
        step(idle(5, 0, 5, 1), 1'b1);
        s = idle(5, 0, 5, 1); s.ao_e = 1'b1; s.ao_a = 5'd5; s.ao_d = 64'h1234; step(s, 1'b1);
        step(idle(5, 0, 5, 1), 1'b1);

        // Three in flight to x7, all three ports retire together.
        s = idle(7, 7, 0, 0); s.d0_e = 1'b1; s.d0_rd = 5'd7; s.d1_e = 1'b1; s.d1_rd = 5'd7; step(s, 1'b1);
        s = idle(7, 7, 0, 0); s.d0_e = 1'b1; s.d0_rd = 5'd7; step(s, 1'b1);
        s = idle(7, 0, 0, 0);
        s.ao_e = 1'b1; s.ao_a = 5'd7; s.ao_d = 64'hA;
        s.at_e = 1'b1; s.at_a = 5'd7; s.at_d = 64'hB;
        s.mm_e = 1'b1; s.mm_a = 5'd7; s.mm_d = 64'hC;
        step(s, 1'b1);
        step(idle(7, 7, 7, 7), 1'b1);

        // Saturate x9, reject the fourth, then write+dispatch together.
        for (int k = 0; k < 4; k++) begin
            s = idle(9, 0, 0, 0); s.d0_e = 1'b1; s.d0_rd = 5'd9; step(s, 1'b1);
        end
        s = idle(9, 0, 0, 0); s.d0_e = 1'b1; s.d0_rd = 5'd9;
        s.ao_e = 1'b1; s.ao_a = 5'd9; s.ao_d = 64'h99; step(s, 1'b1);
        s = idle(9, 0, 0, 0); s.d1_e = 1'b1; s.d1_rd = 5'd9; step(s, 1'b1);
        s = idle(9, 0, 0, 0);
        s.ao_e = 1'b1; s.ao_a = 5'd9; s.ao_d = 64'h91;
        s.at_e = 1'b1; s.at_a = 5'd9; s.at_d = 64'h92;
        s.mm_e = 1'b1; s.mm_a = 5'd9; s.mm_d = 64'h93;
        step(s, 1'b1);
        step(idle(9, 0, 0, 0), 1'b1);

        // Underflow on x3, then writes and dispatches to x0.
        s = idle(3, 0, 0, 0); s.ao_e = 1'b1; s.ao_a = 5'd3; s.ao_d = 64'h33; step(s, 1'b1);
        step(idle(3, 0, 0, 0), 1'b1);
        s = idle(0, 0, 0, 0); s.ao_e = 1'b1; s.ao_a = 5'd0; s.ao_d = 64'hFF;
        s.d0_e = 1'b1; s.d0_rd = 5'd0; step(s, 1'b1);
        step(idle(0, 3, 0, 0), 1'b1);

        // Reset while x4 pending and being written.
        s = idle(4, 0, 0, 0); s.d0_e = 1'b1; s.d0_rd = 5'd4; step(s, 1'b1);
        s = idle(4, 0, 0, 0); s.rst = 1'b1; s.mm_e = 1'b1; s.mm_a = 5'd4; s.mm_d = 64'h44;
        s.d1_e = 1'b1; s.d1_rd = 5'd4; step(s, 1'b1);
        step(idle(4, 3, 7, 0), 1'b1);

        for (int c = 0; c < 2000; c++) begin
            s       = '0;
            s.rst   = ($urandom_range(0, 99) == 0);
            s.ao_e  = ($urandom_range(0, 9) < 4); s.ao_a = pick_wr(); s.ao_d = {$urandom, $urandom};
            s.at_e  = ($urandom_range(0, 9) < 4); s.at_a = pick_wr(); s.at_d = {$urandom, $urandom};
            s.mm_e  = ($urandom_range(0, 9) < 4); s.mm_a = pick_wr(); s.mm_d = {$urandom, $urandom};
            s.d0_e  = ($urandom_range(0, 9) < 5); s.d0_rd = 5'($urandom_range(0, 11));
            s.d1_e  = ($urandom_range(0, 9) < 5); s.d1_rd = 5'($urandom_range(0, 11));
            for (int i = 0; i < 4; i++) s.rs_a[i] = 5'($urandom_range(0, 11));
            step(s, 1'b1);
        end

        repeat (3) @(negedge clk);
        cmp("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
